mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive denied fetch cycles before fetch is forced a grant.
REQ-002 Parameter IV_ADDR, default 8'h01: memory address of the interrupt vector.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 if_req  in  1  fetch stage requests an instruction read; if_addr  in  8  fetch address.
REQ-006 dm_req  in  1  memory stage requests access; dm_we  in  1  1=write; dm_addr  in  8; dm_wdata  in  8.
REQ-007 iv_req  in  1  one-cycle pulse from fetch control requesting an interrupt-vector read.
REQ-008 mem_addr  out  8; mem_we  out  1; mem_wdata  out  8: shared single-port memory drive.
REQ-009 mem_rdata  in  8  combinational read data for the current mem_addr.
REQ-010 if_gnt, dm_gnt, iv_gnt  out  1 each: one-hot (or all zero) grant for this cycle.
REQ-011 rdata  out  8  mem_rdata forwarded to the granted reader, same cycle.
REQ-012 if_stall, dm_stall  out  1 each: request present and not granted this cycle.
REQ-013 iv_vec  out  8  registered vector; iv_done  out  1  one-cycle pulse when iv_vec is valid.
REQ-014 gnt_state  out  2  registered last grant: 0=NONE, 1=IF, 2=DM, 3=IV.
REQ-015 stall_cnt  out  8  saturating count of cycles with if_stall or dm_stall high.

Function
REQ-016 iv_req SHALL set iv_pending on the next edge; iv_pending SHALL clear on the edge ending an iv_gnt cycle.
REQ-017 Grant priority per cycle SHALL be: iv_pending > forced fetch (starve_cnt==STARVE_MAX and if_req) > dm_req > if_req.
REQ-018 Grants SHALL be combinational from requests and registered state; at most one grant high per cycle.
REQ-019 iv_gnt cycle: mem_addr=IV_ADDR, mem_we=0; iv_vec SHALL capture mem_rdata at that edge; iv_done SHALL pulse the following cycle.
REQ-020 dm_gnt cycle: mem_addr=dm_addr, mem_we=dm_we, mem_wdata=dm_wdata; if_gnt cycle: mem_addr=if_addr, mem_we=0.
REQ-021 No grant: mem_we=0, mem_addr=if_addr, mem_wdata=0.
REQ-022 mem_we SHALL never be high except during dm_gnt with dm_we=1.
REQ-023 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment when if_req and not if_gnt, saturate at STARVE_MAX, and clear when if_gnt or not if_req.
REQ-024 A forced fetch grant SHALL stall dm for exactly that cycle; starve_cnt then restarts from 0.
REQ-025 iv_req arriving while iv_pending is already set SHALL be absorbed (no second read, one iv_done).
REQ-026 iv_req and dm_req in the same cycle: dm granted that cycle (iv_pending not yet set), iv granted next cycle.
REQ-027 gnt_state SHALL register the grant encoding every edge, NONE when no grant.
REQ-028 stall_cnt SHALL increment by 1 per stalled cycle and hold at 8'hFF.

Reset
REQ-029 On rst: iv_pending=0, starve_cnt=0, iv_vec=8'h00, iv_done=0, gnt_state=0, stall_cnt=0, asynchronously.
REQ-030 During rst all grants and mem_we SHALL be 0; a pending vector read is dropped with no iv_done.
REQ-031 First arbitration SHALL occur on the first rising edge after rst deasserts.

Structure
REQ-032 Package mem_arb_pkg SHALL hold gnt_state encodings, STARVE_MAX and IV_ADDR defaults.
REQ-033 Starvation counter SHALL be sub-module mem_arb_starve_cnt (inputs req, gnt; output force).
REQ-034 All remaining logic (priority mux, vector register, stall counter) SHALL be in mem_port_arbiter.

Verification
REQ-035 if_req=1 only, if_addr=8'h10 -> if_gnt=1, mem_addr=8'h10, if_stall=0, gnt_state=1 next cycle.
REQ-036 if_req and dm_req (dm_we=1, addr 8'h80, data 8'h5A) held 5 cycles -> dm granted cycles 1-3, fetch forced cycle 4, dm cycle 5; mem_we low in cycle 4.
REQ-037 iv_req pulse, mem holds 8'h3C at 8'h01 -> iv_gnt next cycle with mem_addr=8'h01, iv_vec=8'h3C and iv_done pulse one cycle later.
REQ-038 iv_req with dm_req same cycle, then iv_req again while pending -> dm, then single iv_gnt, single iv_done.
REQ-039 rst asserted mid-cycle while iv_pending=1 -> grants and mem_we drop immediately, no iv_done after release, counters 0.
REQ-040 dm_req held 300 cycles with if_req=1 -> stall_cnt saturates at 8'hFF, never wraps.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default parameters for the memory port arbiter.
package mem_arb_pkg;

  localparam int         STARVE_MAX_DEF = 3;
  localparam logic [7:0] IV_ADDR_DEF    = 8'h01;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2,
    GNT_IV   = 2'd3
  } gnt_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter. slave = arbiter side, master = requesters/memory.
// Handshake: a request is a level held by the requester; the matching *_gnt is the same-cycle
// acknowledge, and a request with no grant in a cycle shows up as *_stall for that cycle.
interface mem_port_arbiter_if;
  logic       if_req;
  logic [7:0] if_addr;
  logic       dm_req;
  logic       dm_we;
  logic [7:0] dm_addr;
  logic [7:0] dm_wdata;
  logic       iv_req;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       if_gnt;
  logic       dm_gnt;
  logic       iv_gnt;
  logic [7:0] rdata;
  logic       if_stall;
  logic       dm_stall;
  logic [7:0] iv_vec;
  logic       iv_done;
  logic [1:0] gnt_state;
  logic [7:0] stall_cnt;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, iv_req, mem_rdata,
    output mem_addr, mem_we, mem_wdata, if_gnt, dm_gnt, iv_gnt, rdata,
           if_stall, dm_stall, iv_vec, iv_done, gnt_state, stall_cnt
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, iv_req, mem_rdata,
    input  mem_addr, mem_we, mem_wdata, if_gnt, dm_gnt, iv_gnt, rdata,
           if_stall, dm_stall, iv_vec, iv_done, gnt_state, stall_cnt
  );
endinterface

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive denied fetch cycles; force_fetch asks for a fetch grant once the limit is hit.
module mem_arb_starve_cnt #(
  parameter int STARVE_MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic force_fetch
);
  localparam int W = $clog2(STARVE_MAX + 1);
  localparam logic [W-1:0] LIMIT = W'(STARVE_MAX);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (!req || gnt)   cnt <= '0;
    else if (cnt != LIMIT)  cnt <= cnt + 1'b1;
  end

  assign force_fetch = req && (cnt == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch, data memory and interrupt-vector reads,
// with starvation protection for fetch and a saturating stall counter.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         STARVE_MAX = STARVE_MAX_DEF,
  parameter logic [7:0] IV_ADDR    = IV_ADDR_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);
  gnt_state_e gnt_sel;
  gnt_state_e gnt_q;
  logic       iv_pending;
  logic       force_fetch;
  logic       if_gnt, dm_gnt, iv_gnt;
  logic       stalled;

  mem_arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.if_req),
    .gnt         (if_gnt),
    .force_fetch (force_fetch)
  );

  // State register: last grant, pending vector read, vector capture, stall count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= GNT_NONE;
      iv_pending <= 1'b0;
      bus.iv_vec <= 8'h00;
      bus.iv_done <= 1'b0;
      bus.stall_cnt <= 8'h00;
    end else begin
      gnt_q       <= gnt_sel;
      // A request arriving while one is pending (or being served) is absorbed.
      iv_pending  <= iv_gnt ? 1'b0 : (iv_pending | bus.iv_req);
      bus.iv_done <= iv_gnt;
      if (iv_gnt) bus.iv_vec <= bus.mem_rdata;
      if (stalled && bus.stall_cnt != 8'hFF) bus.stall_cnt <= bus.stall_cnt + 8'd1;
    end
  end

  // Next-state: priority selection, nothing granted while reset is held.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (!rst) begin
      if (iv_pending)       gnt_sel = GNT_IV;
      else if (force_fetch) gnt_sel = GNT_IF;
      else if (bus.dm_req)  gnt_sel = GNT_DM;
      else if (bus.if_req)  gnt_sel = GNT_IF;
    end
  end

  assign if_gnt  = (gnt_sel == GNT_IF);
  assign dm_gnt  = (gnt_sel == GNT_DM);
  assign iv_gnt  = (gnt_sel == GNT_IV);
  assign stalled = bus.if_stall | bus.dm_stall;

  // Outputs: memory drive mux and per-requester status.
  always_comb begin
    bus.mem_addr  = bus.if_addr;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = 8'h00;
    bus.rdata     = 8'h00;
    unique case (gnt_sel)
      GNT_IV: begin
        bus.mem_addr = IV_ADDR;
        bus.rdata    = bus.mem_rdata;
      end
      GNT_DM: begin
        bus.mem_addr  = bus.dm_addr;
        bus.mem_we    = bus.dm_we;
        bus.mem_wdata = bus.dm_wdata;
        bus.rdata     = bus.dm_we ? 8'h00 : bus.mem_rdata;
      end
      GNT_IF: begin
        bus.rdata = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.iv_gnt    = iv_gnt;
  assign bus.if_stall  = bus.if_req & ~if_gnt;
  assign bus.dm_stall  = bus.dm_req & ~dm_gnt;
  assign bus.gnt_state = gnt_q;
endmodule
